uart_tx: RTL

UART transmitter that serialises one parallel word per request into an asynchronous frame: start bit, data bits LSB first, optional parity, one stop bit. It has an internal baud-period counter, with the bit period expressed in clk cycles. It sits opposite the UART receive path and uses the same bit-period parameterisation, 434 clocks per bit (50 MHz / 115200). Handshake to the host is start/busy/done.

---
 rtl/uart_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, one stop bit.
// Each bit is held for CLKS_PER_BIT clk cycles; host handshake is tx_start / busy / done.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_baud;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;

  logic                 w_wrap;
  logic [DATA_BITS-1:0] w_shift_nxt;

  assign w_wrap      = (r_baud == BAUD_LAST);
  assign w_shift_nxt = r_shift >> 1;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done   <= 1'b0;
      r_baud <= (r_state == S_IDLE || w_wrap) ? '0 : r_baud + CW'(1);

      case (r_state)
        S_IDLE: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          r_bit <= '0;
          if (tx_start) begin
            r_state  <= S_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            r_shift  <= tx_data;
            r_parity <= parity_of(tx_data);
          end
        end

        S_START: begin
          if (w_wrap) begin
            r_state <= S_DATA;
            tx      <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_wrap) begin
            r_shift <= w_shift_nxt;
            if (r_bit == BIT_LAST) begin
              r_bit <= '0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                tx      <= r_parity;
              end else begin
                r_state <= S_STOP;
                tx      <= 1'b1;
              end
            end else begin
              r_bit <= r_bit + BW'(1);
              tx    <= w_shift_nxt[0];
            end
          end
        end

        S_PARITY: begin
          if (w_wrap) begin
            r_state <= S_STOP;
            tx      <= 1'b1;
          end
        end

        S_STOP: begin
          if (w_wrap) begin
            done <= 1'b1;
            // A request seen on the last stop cycle chains straight into the next
            // start bit, so a held tx_start yields frames with no idle gap.
            if (tx_start) begin
              r_state  <= S_START;
              tx       <= 1'b0;
              busy     <= 1'b1;
              r_shift  <= tx_data;
              r_parity <= parity_of(tx_data);
            end else begin
              r_state <= S_IDLE;
              tx      <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
